gate_sweep_ctrl: RTL
====================

// Module: gate_sweep_ctrl
// PURPOSE
//   Sequencer for exhaustive checking of one combinational logic gate (AND by default).
//   Drives the gate inputs through every vector 0..2^N_IN-1 and holds each one for
//   HOLD_CYCLES clocks.
//   Samples the gate output at the end of each hold and compares it against EXP_TT.
//   Reports error count, first failing vector and pass/fail.
//   Sits between a start/abort control source and the gate under check.
// PARAMETERS
//   N_IN         2        gate input count; legal range 1..8
//   HOLD_CYCLES  4        clocks each vector is held before sampling; must be >= 1
//   EXP_TT       4'b1000  expected truth table, width 2^N_IN; bit i = expected gate_y for vector i
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous, active-low reset
//   start       in   1        begin a sweep; honoured only in IDLE or DONE
//   abort       in   1        cancel a running sweep
//   gate_y      in   1        output of the gate under check
//   vec_out     out  N_IN     registered input vector driven to the gate
//   busy        out  1        sweep in progress
//   done        out  1        sweep finished; held until next start, abort or reset
//   pass        out  1        done && err_count==0
//   err_count   out  N_IN+1   number of mismatching vectors
//   fail_valid  out  1        at least one mismatch recorded
//   fail_vec    out  N_IN     first mismatching vector
// BEHAVIOUR
//   - Reset (async assert, sync release): every output = 0.
//     Internal state: IDLE, vec_idx=0, hold_cnt=0.
//   - FSM states: IDLE, DRIVE, DONE. All outputs are registered.
//   - IDLE/DONE + start=1: next state is DRIVE.
//     - Cleared: vec_idx, hold_cnt, err_count, fail_valid, fail_vec, done.
//     - busy=1 from the following cycle.
//   - DRIVE:
//     - vec_out = vec_idx; hold_cnt increments every cycle.
//     - When hold_cnt == HOLD_CYCLES-1, gate_y is compared to EXP_TT[vec_idx] on that edge.
//     - On mismatch: err_count += 1.
//     - On the first mismatch only: fail_vec = vec_idx and fail_valid = 1.
//   - After the compare:
//     - If vec_idx == 2^N_IN-1: go to DONE. done=1, busy=0, vec_out returns to 0.
//     - Otherwise: vec_idx += 1 and hold_cnt = 0. No idle gap between vectors.
//   - Latency: start sampled at edge k gives done=1 after edge k+1+2^N_IN*HOLD_CYCLES.
//   - err_count width N_IN+1 holds the maximum 2^N_IN without wrap.
//     vec_idx never wraps: the terminal vector exits to DONE.
//   - start while in DRIVE: ignored, with no restart and no effect on counters.
//   - abort in DRIVE: next state IDLE, busy=0, done=0, vec_out=0.
//     - err_count, fail_* keep partial values until the next start.
//     - abort in IDLE/DONE: no effect.
//   - start and abort in the same cycle: abort wins in DRIVE; start wins in IDLE/DONE.
//   - rst_n low mid-sweep: immediate return to reset values; no done pulse.
//   - pass is valid only while done=1; it is 0 at all other times.
// TESTING
//   1. Defaults, gate_y = a&b model, 1-cycle start:
//      - vec_out = 00,01,10,11 for 4 cycles each.
//      - done=1 17 cycles after the start edge; pass=1, err_count=0, fail_valid=0.
//   2. gate_y stuck at 0: err_count=1, fail_vec=2'b11, fail_valid=1, pass=0.
//   3. gate_y = a|b model: err_count=2, fail_vec=2'b01 (first mismatch), pass=0.
//   4. abort asserted while vec_out=2'b10:
//      - Next cycle busy=0, done=0, vec_out=0.
//      - A following start completes normally with pass=1.
//   5. start pulsed again mid-sweep: ignored, total sweep still 16 DRIVE cycles.
//      rst_n pulsed low mid-sweep: all outputs 0 asynchronously, state IDLE.
//   6. HOLD_CYCLES=1, N_IN=3, EXP_TT=8'h80, 3-input AND model:
//      - vec_out steps every cycle 0..7.
//      - done=1 9 cycles after start; pass=1.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for one combinational gate.
// It steps every input vector, samples the gate output and keeps a mismatch log.
module gate_sweep_ctrl #(
    parameter int                    N_IN        = 2,
    parameter int                    HOLD_CYCLES = 4,
    parameter logic [2**N_IN-1:0]    EXP_TT      = 4'b1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              gate_y,
    output logic [N_IN-1:0]   vec_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   fail_vec
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [N_IN-1:0] vec_idx;
    logic [HW-1:0]   hold_cnt;
    logic            start_q;
    logic            miss;

    assign miss = (gate_y != EXP_TT[vec_idx]);

    // start is registered once; a request seen during DRIVE is dropped here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            vec_idx    <= '0;
            hold_cnt   <= '0;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            start_q <= start && (state != DRIVE);
            unique case (state)
                IDLE, DONE: begin
                    if (start_q) begin
                        state      <= DRIVE;
                        vec_idx    <= '0;
                        hold_cnt   <= '0;
                        vec_out    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        vec_out  <= '0;
                        vec_idx  <= '0;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        if (miss) begin
                            err_count <= err_count + 1'b1;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                fail_vec   <= vec_idx;
                            end
                        end
                        if (vec_idx == VEC_LAST) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= !miss && (err_count == '0);
                            vec_out <= '0;
                        end else begin
                            vec_idx  <= vec_idx + 1'b1;
                            vec_out  <= vec_idx + 1'b1;
                            hold_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
